// File: rtl/rst_seq_if.sv
// rst_seq_if: reset request inputs and staged reset / cause outputs of rst_seq
interface rst_seq_if #(parameter int NREQ = 4, parameter int NSTAGE = 3);
  logic              clk_ok;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_mask;
  logic              cause_clr;
  logic [NSTAGE-1:0] rst_stage;
  logic              rst_busy;
  logic [NREQ:0]     cause;
  logic              por;
  modport master (output clk_ok, req, req_mask, cause_clr, input rst_stage, rst_busy, cause, por);
  modport slave (input clk_ok, req, req_mask, cause_clr, output rst_stage, rst_busy, cause, por);
endinterface

// File: rtl/rst_seq.sv
// rst_seq: collects reset triggers, holds all domains, then releases them one stage at a time
module rst_seq #(
  parameter int NREQ     = 4,
  parameter int NSTAGE   = 3,
  parameter int HOLD_CYC = 24'hFFFFFF,
  parameter int GAP      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  rst_seq_if.slave   bus
);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam int IW = $clog2(NSTAGE + 1);
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;
  state_t            state, state_n;
  logic [HW-1:0]     hold, hold_n;
  logic [GW-1:0]     gap, gap_n;
  logic [IW-1:0]     idx, idx_n;
  logic [NSTAGE-1:0] stage_n;
  logic [NREQ:0]     trig_vec;
  logic              trig;
  assign trig_vec = {~bus.clk_ok, bus.req & ~bus.req_mask};
  assign trig     = |trig_vec;
  // any trigger restarts the full hold from every state
  always_comb begin
    state_n = state;
    hold_n  = hold;
    gap_n   = gap;
    idx_n   = idx;
    stage_n = bus.rst_stage;
    if (trig) begin
      state_n = HOLD;
      hold_n  = '0;
      gap_n   = '0;
      idx_n   = '0;
      stage_n = '1;
    end else if (state == HOLD) begin
      if (hold == HW'(HOLD_CYC - 1)) begin
        stage_n = bus.rst_stage & ~NSTAGE'(1);
        gap_n   = '0;
        idx_n   = IW'(1);
        state_n = (NSTAGE == 1) ? RUN : RELEASE;
      end else hold_n = hold + HW'(1);
    end else if (state == RELEASE) begin
      if (gap == GW'(GAP - 1)) begin
        stage_n = bus.rst_stage & ~(NSTAGE'(1) << idx);
        gap_n   = '0;
        idx_n   = idx + IW'(1);
        state_n = (idx == IW'(NSTAGE - 1)) ? RUN : RELEASE;
      end else gap_n = gap + GW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= HOLD;
      hold          <= '0;
      gap           <= '0;
      idx           <= '0;
      bus.rst_stage <= '1;
      bus.rst_busy  <= 1'b1;
      bus.cause     <= '0;
      bus.por       <= 1'b1;
    end else begin
      state         <= state_n;
      hold          <= hold_n;
      gap           <= gap_n;
      idx           <= idx_n;
      bus.rst_stage <= stage_n;
      bus.rst_busy  <= |stage_n;
      bus.cause     <= bus.cause_clr ? trig_vec : (bus.cause | trig_vec);
      bus.por       <= bus.por & ~bus.cause_clr;
    end
  end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed checks of hold timing, staged release, cause and por
module tb_rst_seq;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  rst_seq_if #(.NREQ(4), .NSTAGE(3)) bus ();
  rst_seq #(.NREQ(4), .NSTAGE(3), .HOLD_CYC(16), .GAP(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // called right after the last trigger edge: stage 0 falls 16 edges later, then every 4
  task automatic seq_check(input string tag);
    tick(15);
    chk({tag, "_hold15"}, bus.rst_stage, 3'b111);
    tick();
    chk({tag, "_s0"}, bus.rst_stage, 3'b110);
    tick(3);
    chk({tag, "_gap3"}, bus.rst_stage, 3'b110);
    tick();
    chk({tag, "_s1"}, bus.rst_stage, 3'b100);
    tick(3);
    chk({tag, "_busy_pre"}, bus.rst_busy, 1'b1);
    tick();
    chk({tag, "_s2"}, bus.rst_stage, 3'b000);
    chk({tag, "_busy"}, bus.rst_busy, 1'b0);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.clk_ok = 1'b1;
    bus.req = '0;
    bus.req_mask = '0;
    bus.cause_clr = 1'b0;
    tick(2);
    chk("rst_stage", bus.rst_stage, 3'b111);
    chk("rst_busy", bus.rst_busy, 1'b1);
    chk("rst_cause", bus.cause, 5'b00000);
    chk("rst_por", bus.por, 1'b1);
    rst_n = 1'b1;
    seq_check("t1");
    chk("t1_cause", bus.cause, 5'b00000);
    chk("t1_por", bus.por, 1'b1);
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    chk("t2_stage", bus.rst_stage, 3'b111);
    chk("t2_cause", bus.cause, 5'b00010);
    seq_check("t2");
    bus.req = 4'b0001;
    tick(10);
    chk("t3_held", bus.rst_stage, 3'b111);
    bus.req = '0;
    seq_check("t3");
    chk("t3_cause", bus.cause, 5'b00011);
    bus.req_mask = 4'b0100;
    bus.req = 4'b0100;
    tick(3);
    chk("t5_stage", bus.rst_stage, 3'b000);
    chk("t5_cause", bus.cause, 5'b00011);
    bus.req = '0;
    bus.req_mask = '0;
    bus.cause_clr = 1'b1;
    bus.req = 4'b1000;
    tick();
    bus.cause_clr = 1'b0;
    bus.req = '0;
    chk("t6_cause", bus.cause, 5'b01000);
    chk("t6_por", bus.por, 1'b0);
    chk("t6_stage", bus.rst_stage, 3'b111);
    seq_check("t6");
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    tick(17);
    chk("t4_pre", bus.rst_stage, 3'b110);
    bus.clk_ok = 1'b0;
    tick();
    bus.clk_ok = 1'b1;
    chk("t4_stage", bus.rst_stage, 3'b111);
    chk("t4_cause", bus.cause, 5'b11001);
    seq_check("t4");
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    chk("clr_cause", bus.cause, 5'b00000);
    chk("clr_stage", bus.rst_stage, 3'b000);
    rst_n = 1'b0;
    bus.req = 4'b0100;
    tick();
    chk("rst2_stage", bus.rst_stage, 3'b111);
    chk("rst2_por", bus.por, 1'b1);
    chk("rst2_cause", bus.cause, 5'b00000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
